iir_mac_seq: RTL and testbench

//  Time-shared multiply-accumulate stage for a second-order filter section.

---
 rtl/iir_mac_seq_pkg.sv | 15 +
 rtl/iir_mac_seq_if.sv | 28 ++
 rtl/iir_mac_seq_fx_mul_trunc.sv | 17 +
 rtl/iir_mac_seq.sv | 114 +++++++++++
 tb/tb_iir_mac_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/iir_mac_seq_pkg.sv
// Shared definitions for the time-shared second-order MAC stage:
// default word geometry and the sequencer state encoding.
package iir_mac_seq_pkg;
    localparam int N_DEF = 25;
    localparam int F_DEF = N_DEF;
    localparam int TAPS  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        OUT  = 3'd4
    } state_t;
endpackage

// File: rtl/iir_mac_seq_if.sv
// Sample/coefficient bus between the history register, the MAC stage and its consumer.
interface iir_mac_seq_if
    import iir_mac_seq_pkg::*;
#(
    parameter int N = N_DEF
);
    logic                  start;
    logic signed [2*N-1:0] fk;
    logic signed [2*N-1:0] fk_1;
    logic signed [2*N-1:0] fk_2;
    logic signed [2*N-1:0] b0;
    logic signed [2*N-1:0] b1;
    logic signed [2*N-1:0] b2;
    logic signed [2*N-1:0] y;
    logic                  done;
    logic                  shift;
    logic                  busy;

    modport master (
        output start, fk, fk_1, fk_2, b0, b1, b2,
        input  y, done, shift, busy
    );

    modport slave (
        input  start, fk, fk_1, fk_2, b0, b1, b2,
        output y, done, shift, busy
    );
endinterface

// File: rtl/iir_mac_seq_fx_mul_trunc.sv
// Combinational signed 2N x 2N multiply, arithmetic right shift by F (floor),
// sign-extended to the 4N+2 bit accumulator width.
module fx_mul_trunc #(
    parameter int N = 25,
    parameter int F = 25
) (
    input  logic signed [2*N-1:0] a,
    input  logic signed [2*N-1:0] b,
    output logic signed [4*N+1:0] p
);
    logic signed [4*N-1:0] prod;
    logic signed [4*N-1:0] shifted;

    assign prod    = $signed((4*N)'(a)) * $signed((4*N)'(b));
    assign shifted = prod >>> F;
    assign p       = {{2{shifted[4*N-1]}}, shifted};
endmodule

// File: rtl/iir_mac_seq.sv
// Second-order section MAC: one shared multiplier walks b0*f(k), b1*f(k-1), b2*f(k-2)
// over three cycles, then saturates into y and strobes done/shift together.
module iir_mac_seq
    import iir_mac_seq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int F = F_DEF
) (
    input  logic        clk,
    input  logic        reset,
    iir_mac_seq_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int AW = 4 * N + 2;

    localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] a);
        if (a > SAT_HI)      return SAT_HI[W-1:0];
        else if (a < SAT_LO) return SAT_LO[W-1:0];
        else                 return a[W-1:0];
    endfunction

    state_t state, state_nxt;
    logic   load, acc_en, out_en;

    logic signed [W-1:0]  f_p0 [TAPS];
    logic signed [W-1:0]  b_p0 [TAPS];
    logic signed [W-1:0]  mul_a, mul_b;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc_p1;
    logic signed [W-1:0]  y_p2;
    logic                 done_p2, shift_p2;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        acc_en    = 1'b0;
        out_en    = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        unique case (state)
            IDLE: if (bus.start) begin
                load      = 1'b1;
                state_nxt = M0;
            end
            M0: begin
                acc_en    = 1'b1;
                mul_a     = f_p0[0];
                mul_b     = b_p0[0];
                state_nxt = M1;
            end
            M1: begin
                acc_en    = 1'b1;
                mul_a     = f_p0[1];
                mul_b     = b_p0[1];
                state_nxt = M2;
            end
            M2: begin
                acc_en    = 1'b1;
                mul_a     = f_p0[2];
                mul_b     = b_p0[2];
                state_nxt = OUT;
            end
            OUT: begin
                out_en    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    fx_mul_trunc #(.N(N), .F(F)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (term)
    );

    // Stage p0: operand snapshot, so later history changes cannot disturb this sample
    always_ff @(posedge clk) begin
        if (load) begin
            f_p0[0] <= bus.fk;
            f_p0[1] <= bus.fk_1;
            f_p0[2] <= bus.fk_2;
            b_p0[0] <= bus.b0;
            b_p0[1] <= bus.b1;
            b_p0[2] <= bus.b2;
        end
    end

    // Stage p1/p2: accumulate, then saturate into y with a one-cycle done/shift strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc_p1   <= '0;
            y_p2     <= '0;
            done_p2  <= 1'b0;
            shift_p2 <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_p2  <= out_en;
            shift_p2 <= out_en;
            if (load)        acc_p1 <= '0;
            else if (acc_en) acc_p1 <= acc_p1 + term;
            if (out_en)      y_p2   <= sat(acc_p1);
        end
    end

    assign bus.y     = y_p2;
    assign bus.done  = done_p2;
    assign bus.shift = shift_p2;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_iir_mac_seq.sv
// Randomised and directed bench for iir_mac_seq against a floor-division reference model.
module tb_iir_mac_seq;
    localparam int N   = 25;
    localparam int F   = 25;
    localparam int W   = 2 * N;
    localparam logic signed [W-1:0] ONE = 50'sd33554432;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    iir_mac_seq_if #(.N(N)) bus ();

    iir_mac_seq #(.N(N), .F(F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: sum of floor(b_i*f_i / 2^F), clamped to the signed W-bit range
    function automatic logic signed [W-1:0] model(
        input logic signed [W-1:0] f0, f1, f2, c0, c1, c2);
        logic signed [127:0] fv [3];
        logic signed [127:0] cv [3];
        logic signed [127:0] p, q, s, hi, lo, one;
        fv[0] = f0; fv[1] = f1; fv[2] = f2;
        cv[0] = c0; cv[1] = c1; cv[2] = c2;
        one = 128'sd33554432;
        s   = '0;
        for (int i = 0; i < 3; i++) begin
            p = fv[i] * cv[i];
            q = p / one;
            if ((p % one) != 0 && p < 0) q = q - 128'sd1;
            s = s + q;
        end
        hi = (128'sd1 <<< (W-1)) - 128'sd1;
        lo = -(128'sd1 <<< (W-1));
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] rnd_word();
        logic signed [W-1:0] r;
        r = W'({$urandom(), $urandom()});
        return r >>> $urandom_range(0, 45);
    endfunction

    task automatic set_ops(input logic signed [W-1:0] f0, f1, f2, c0, c1, c2);
        bus.fk = f0; bus.fk_1 = f1; bus.fk_2 = f2;
        bus.b0 = c0; bus.b1 = c1; bus.b2 = c2;
    endtask

    // One start pulse, then observe nine cycles; latency counted in edges after the start edge
    task automatic do_sample(input logic signed [W-1:0] f0, f1, f2, c0, c1, c2,
                             output int lat, output int ndone, output int strobe_bad,
                             output logic busy1, output logic signed [W-1:0] yv);
        logic prev_done;
        set_ops(f0, f1, f2, c0, c1, c2);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        busy1      = bus.busy;
        lat        = -1;
        ndone      = 0;
        strobe_bad = 0;
        prev_done  = 1'b0;
        yv         = '0;
        for (int k = 1; k <= 9; k++) begin
            if (bus.shift !== bus.done) strobe_bad++;
            if (bus.done === 1'b1) begin
                if (prev_done) strobe_bad++;
                if (lat < 0) lat = k - 1;
                ndone++;
                yv = bus.y;
            end
            prev_done = (bus.done === 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        set_ops(50'sd5, 50'sd5, 50'sd5, ONE, ONE, ONE);
        repeat (3) @(negedge clk);
        checks++; if (bus.y !== '0)    begin errors++; $display("FAIL reset_y got %0d want 0", bus.y); end
        checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.shift !== 1'b0) begin errors++; $display("FAIL reset_shift got %b want 0", bus.shift); end
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unity();
        int lat, nd, sb; logic b1v; logic signed [W-1:0] yv;
        do_sample(50'sd1000, 50'sd0, 50'sd0, ONE, 50'sd0, 50'sd0, lat, nd, sb, b1v, yv);
        checks++; if (yv !== 50'sd1000) begin errors++; $display("FAIL unity_y got %0d want 1000", yv); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL unity_latency got %0d want 4", lat); end
        checks++; if (nd !== 1)  begin errors++; $display("FAIL unity_pulses got %0d want 1", nd); end
        checks++; if (sb !== 0)  begin errors++; $display("FAIL unity_strobe got %0d want 0", sb); end
        checks++; if (b1v !== 1'b1) begin errors++; $display("FAIL unity_busy got %b want 1", b1v); end
    endtask

    task automatic test_sum();
        int lat, nd, sb; logic b1v; logic signed [W-1:0] yv;
        do_sample(50'sd10, -50'sd4, 50'sd7, ONE, ONE, ONE, lat, nd, sb, b1v, yv);
        checks++; if (yv !== 50'sd13) begin errors++; $display("FAIL sum_y got %0d want 13", yv); end
        checks++; if (nd !== 1 || sb !== 0) begin errors++; $display("FAIL sum_pulses got %0d/%0d want 1/0", nd, sb); end
    endtask

    task automatic test_trunc();
        int lat, nd, sb; logic b1v; logic signed [W-1:0] yv;
        do_sample(-50'sd3, 50'sd0, 50'sd0, 50'sd16777216, 50'sd0, 50'sd0, lat, nd, sb, b1v, yv);
        checks++; if (yv !== -50'sd2) begin errors++; $display("FAIL trunc_y got %0d want -2", yv); end
    endtask

    task automatic test_saturate();
        int lat, nd, sb; logic b1v; logic signed [W-1:0] yv, mx, mn;
        mx = {1'b0, {(W-1){1'b1}}};
        mn = {1'b1, {(W-1){1'b0}}};
        do_sample(mx, mx, mx, mx, mx, mx, lat, nd, sb, b1v, yv);
        checks++; if (yv !== mx) begin errors++; $display("FAIL sat_pos got %0d want %0d", yv, mx); end
        do_sample(-mx, -mx, -mx, mx, mx, mx, lat, nd, sb, b1v, yv);
        checks++; if (yv !== mn) begin errors++; $display("FAIL sat_neg got %0d want %0d", yv, mn); end
    endtask

    task automatic test_ignore_start();
        int nd; logic signed [W-1:0] yv, exp;
        exp = model(50'sd100, 50'sd20, -50'sd3, ONE, ONE, ONE);
        set_ops(50'sd100, 50'sd20, -50'sd3, ONE, ONE, ONE);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        set_ops(50'sd9999, 50'sd8888, 50'sd7777, ONE, ONE, ONE);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0; yv = '0;
        for (int k = 3; k <= 12; k++) begin
            if (bus.done === 1'b1) begin nd++; yv = bus.y; end
            @(negedge clk);
        end
        checks++; if (nd !== 1)   begin errors++; $display("FAIL ignore_pulses got %0d want 1", nd); end
        checks++; if (yv !== exp) begin errors++; $display("FAIL ignore_snapshot got %0d want %0d", yv, exp); end
    endtask

    task automatic test_reset_mid();
        int nd;
        set_ops(50'sd500, 50'sd500, 50'sd500, ONE, ONE, ONE);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.y !== '0)      begin errors++; $display("FAIL midreset_y got %0d want 0", bus.y); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done === 1'b1 || bus.shift === 1'b1) nd++;
            @(negedge clk);
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_strobes got %0d want 0", nd); end
    endtask

    task automatic test_back_to_back();
        int nd, last, gap_bad, ybad;
        logic signed [W-1:0] exp;
        exp = model(50'sd321, -50'sd55, 50'sd12, ONE, 50'sd16777216, -ONE);
        set_ops(50'sd321, -50'sd55, 50'sd12, ONE, 50'sd16777216, -ONE);
        bus.start = 1'b1;
        @(negedge clk);
        nd = 0; last = -1; gap_bad = 0; ybad = 0;
        for (int k = 1; k <= 31; k++) begin
            if (bus.done === 1'b1) begin
                if (last < 0 && k != 5) gap_bad++;
                if (last >= 0 && k - last != 5) gap_bad++;
                if (bus.y !== exp) ybad++;
                last = k;
                nd++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (nd !== 6)      begin errors++; $display("FAIL b2b_pulses got %0d want 6", nd); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_spacing got %0d bad want 0", gap_bad); end
        checks++; if (ybad !== 0)    begin errors++; $display("FAIL b2b_y got %0d bad want 0", ybad); end
    endtask

    task automatic test_random();
        int lat, nd, sb; logic b1v;
        logic signed [W-1:0] f0, f1, f2, c0, c1, c2, yv, exp;
        for (int i = 0; i < 24; i++) begin
            f0 = rnd_word(); f1 = rnd_word(); f2 = rnd_word();
            c0 = rnd_word(); c1 = rnd_word(); c2 = rnd_word();
            exp = model(f0, f1, f2, c0, c1, c2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_sample(f0, f1, f2, c0, c1, c2, lat, nd, sb, b1v, yv);
            checks++;
            if (yv !== exp || lat !== 4 || nd !== 1 || sb !== 0) begin
                errors++;
                $display("FAIL random_%0d got y=%0d lat=%0d n=%0d sb=%0d want y=%0d lat=4 n=1 sb=0",
                         i, yv, lat, nd, sb, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        set_ops('0, '0, '0, '0, '0, '0);
        @(negedge clk);
        test_reset();
        test_unity();
        test_sum();
        test_trunc();
        test_saturate();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end
endmodule
